sd_output_q: RTL

- Parametrised next-generation srdy/drdy output stage: a DEPTH-entry queue whose head is the registered output.
- Every interface signal is registered; unlike a single-entry output stage, ic_drdy is a flop with no combinatorial path from p_drdy.
- Sits at block boundaries where both directions must be timing-closed.
- Also reports occupancy so upstream logic can throttle early.

---
 rtl/sdlib_pkg.sv | 8 +
 rtl/sd_output_q_mem.sv | 18 +
 rtl/sd_output_q.sv | 62 ++++++
 3 files changed

// File: rtl/sdlib_pkg.sv
// sdlib_pkg: shared helpers for the srdy/drdy library blocks
package sdlib_pkg;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/sd_output_q_mem.sv
// sd_output_q_mem: storage behind the head register, sync write and async read
module sd_output_q_mem #(
  parameter int width = 8,
  parameter int entries = 3,
  parameter int pw = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [pw-1:0]    wr_ptr,
  input  logic [width-1:0] wr_data,
  input  logic [pw-1:0]    rd_ptr,
  output logic [width-1:0] rd_data
);
  logic [width-1:0] mem [entries];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/sd_output_q.sv
// sd_output_q: fully registered srdy/drdy output queue whose head is the output register
module sd_output_q
  import sdlib_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int cw = clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_srdy,
  output logic             ic_drdy,
  input  logic [width-1:0] ic_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic [cw-1:0]    usage
);
  localparam int pw = depth > 2 ? clog2(depth - 1) : 1;
  logic [pw-1:0] rd_ptr, wr_ptr;
  logic [width-1:0] rd_data;
  logic [cw-1:0] nxt_usage;
  logic load, drain, rd_en, to_head, wr_en;
  assign load = ic_srdy & ic_drdy;
  assign drain = p_srdy & p_drdy;
  assign rd_en = drain & (usage > cw'(1));
  // the head takes the incoming word directly when it would otherwise be empty
  assign to_head = load & (!p_srdy | (drain & usage == cw'(1)));
  assign wr_en = load & !to_head;
  assign nxt_usage = usage + cw'(load) - cw'(drain);
  always_ff @(posedge clk) begin
    if (reset) begin
      usage <= '0;
      p_srdy <= 1'b0;
      ic_drdy <= 1'b1;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      usage <= nxt_usage;
      p_srdy <= nxt_usage != '0;
      ic_drdy <= nxt_usage < cw'(depth);
      if (wr_en) wr_ptr <= wr_ptr == pw'(depth - 2) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr == pw'(depth - 2) ? '0 : rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rd_en) p_data <= rd_data;
    else if (to_head) p_data <= ic_data;
  sd_output_q_mem #(.width(width), .entries(depth - 1), .pw(pw)) mem (
    .clk(clk),
    .wr_en(wr_en),
    .wr_ptr(wr_ptr),
    .wr_data(ic_data),
    .rd_ptr(rd_ptr),
    .rd_data(rd_data)
  );
`ifndef SYNTHESIS
  a_usage: assert property (@(posedge clk) disable iff (reset) usage <= cw'(depth));
  a_noload_full: assert property (@(posedge clk) disable iff (reset) !(load && usage == cw'(depth)));
  a_stable: assert property (@(posedge clk) disable iff (reset) p_srdy && !p_drdy |=> $stable(p_data));
`endif
endmodule
